// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-master SRAM arbiter.
// Imported by the arbiter top and its round-robin sub-block.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP0 = 2'd1,
        RESP1 = 2'd2
    } resp_state_e;

    function automatic resp_state_e resp_for(input logic [1:0] gnt);
        resp_state_e s;
        s = IDLE;
        if (gnt[0]) begin
            s = RESP0;
        end else if (gnt[1]) begin
            s = RESP1;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a combinational grant.
// prio_q names the master that wins when both request.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (!rst_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Priority always moves to the master that lost (or did not ask).
    always_comb begin
        prio_d = prio_q;
        if (gnt_o[0]) begin
            prio_d = 1'b1;
        end else if (gnt_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master single-port SRAM arbiter, one transaction per cycle,
// fixed one-cycle grant-to-response latency.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    mem_ce_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    logic [1:0]  gnt;
    resp_state_e state_q;
    resp_state_e state_d;
    logic        we_q;
    logic        we_d;

    rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i ({m1_req_i, m0_req_i}),
        .gnt_o (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];

    always_comb begin
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt[0]) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = m0_we_i;
            mem_be_o    = m0_be_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
        end else if (gnt[1]) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = m1_we_i;
            mem_be_o    = m1_be_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    // The owner's access type travels with the response so write acks
    // return zero data.
    always_comb begin
        state_d = resp_for(gnt);
        we_d    = we_q;
        if (|gnt) begin
            we_d = mem_we_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        if (!rst_i) begin
            unique case (state_q)
                RESP0: begin
                    m0_rvalid_o = 1'b1;
                    m0_rdata_o  = we_q ? '0 : mem_rdata_i;
                end
                RESP1: begin
                    m1_rvalid_o = 1'b1;
                    m1_rdata_o  = we_q ? '0 : mem_rdata_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a
// transaction-level model of arbitration and response timing.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_ce, mem_we;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m0_req_i    (m0_req),
        .m0_we_i     (m0_we),
        .m0_be_i     (m0_be),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_we_i     (m1_we),
        .m1_be_i     (m1_be),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .mem_ce_o    (mem_ce),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    // Model state: who owns the response due next cycle, and priority.
    int prio = 0;
    bit pend_v = 0;
    int pend_m = 0;
    bit pend_we = 0;

    always @(negedge clk) begin
        int win;
        logic        e_we;
        logic [3:0]  e_be;
        logic [15:0] e_addr;
        logic [31:0] e_wdata;
        bit rv0, rv1;

        win = -1;
        if (!rst) begin
            if (m0_req && m1_req) win = prio;
            else if (m0_req) win = 0;
            else if (m1_req) win = 1;
        end
        e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
        if (win == 0) begin
            e_we = m0_we; e_be = m0_be;
            e_addr = m0_addr; e_wdata = m0_wdata;
        end else if (win == 1) begin
            e_we = m1_we; e_be = m1_be;
            e_addr = m1_addr; e_wdata = m1_wdata;
        end
        rv0 = !rst && pend_v && pend_m == 0;
        rv1 = !rst && pend_v && pend_m == 1;

        chk("gnt0", 32'(m0_gnt), 32'(win == 0));
        chk("gnt1", 32'(m1_gnt), 32'(win == 1));
        chk("ce", 32'(mem_ce), 32'(win >= 0));
        chk("we", 32'(mem_we), 32'(e_we));
        chk("be", 32'(mem_be), 32'(e_be));
        chk("addr", 32'(mem_addr), 32'(e_addr));
        chk("wdata", mem_wdata, e_wdata);
        chk("rvalid0", 32'(m0_rvalid), 32'(rv0));
        chk("rvalid1", 32'(m1_rvalid), 32'(rv1));
        chk("rdata0", m0_rdata, (rv0 && !pend_we) ? mem_rdata : 32'h0);
        chk("rdata1", m1_rdata, (rv1 && !pend_we) ? mem_rdata : 32'h0);

        if (rst) begin
            prio   = 0;
            pend_v = 0;
        end else begin
            pend_v = (win >= 0);
            if (win >= 0) begin
                pend_m  = win;
                pend_we = e_we;
                prio    = 1 - win;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic pulse_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        mem_rdata = 32'h0;
        clear();
        repeat (2) tick();

        // Requests under reset are ignored.
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("lit_rst_gnt0", 32'(m0_gnt), 0);
        chk("lit_rst_gnt1", 32'(m1_gnt), 0);
        chk("lit_rst_ce", 32'(mem_ce), 0);
        tick();
        rst = 0;
        clear();

        repeat (3) begin
            @(negedge clk);
            chk("lit_idle_ce", 32'(mem_ce), 0);
            chk("lit_idle_rv0", 32'(m0_rvalid), 0);
            tick();
        end

        // m0 read, data returns one cycle later.
        m0_req = 1; m0_addr = 16'h0010; m0_be = 4'hF;
        @(negedge clk);
        chk("lit_rd_gnt0", 32'(m0_gnt), 1);
        chk("lit_rd_addr", 32'(mem_addr), 32'h10);
        chk("lit_rd_we", 32'(mem_we), 0);
        tick();
        clear();
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("lit_rd_rv0", 32'(m0_rvalid), 1);
        chk("lit_rd_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("lit_rd_rv1", 32'(m1_rvalid), 0);
        tick();

        // Continuous contention alternates starting with m0.
        pulse_reset();
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_alt_gnt0", 32'(m0_gnt), 32'(i % 2 == 0));
            chk("lit_alt_gnt1", 32'(m1_gnt), 32'(i % 2 == 1));
            if (i > 0) begin
                chk("lit_alt_rv0", 32'(m0_rvalid), 32'(i % 2 == 1));
                chk("lit_alt_rv1", 32'(m1_rvalid), 32'(i % 2 == 0));
            end
            tick();
        end
        clear();
        @(negedge clk);
        chk("lit_alt_last_rv1", 32'(m1_rvalid), 1);
        tick();

        // m1 write: command fields, then ack with zero data.
        m1_req = 1; m1_we = 1; m1_addr = 16'h0004;
        m1_wdata = 32'h12345678; m1_be = 4'b0011;
        @(negedge clk);
        chk("lit_wr_ce", 32'(mem_ce), 1);
        chk("lit_wr_we", 32'(mem_we), 1);
        chk("lit_wr_be", 32'(mem_be), 32'h3);
        chk("lit_wr_addr", 32'(mem_addr), 32'h4);
        chk("lit_wr_wdata", mem_wdata, 32'h12345678);
        tick();
        clear();
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("lit_wr_rv1", 32'(m1_rvalid), 1);
        chk("lit_wr_rdata1", m1_rdata, 32'h0);
        tick();

        // Reset right after a grant discards the response.
        m1_req = 1;
        @(negedge clk);
        tick();
        clear();
        m0_req = 1;
        @(negedge clk);
        chk("lit_mid_gnt0", 32'(m0_gnt), 1);
        tick();
        rst = 1;
        @(negedge clk);
        chk("lit_mid_rv0_rst", 32'(m0_rvalid), 0);
        tick();
        rst = 0;
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("lit_mid_rv0_after", 32'(m0_rvalid), 0);
        chk("lit_mid_gnt0_after", 32'(m0_gnt), 1);
        chk("lit_mid_gnt1_after", 32'(m1_gnt), 0);
        tick();
        clear();

        // Three solo m0 grants leave priority with m1.
        pulse_reset();
        m0_req = 1;
        repeat (3) begin
            @(negedge clk);
            chk("lit_solo_gnt0", 32'(m0_gnt), 1);
            tick();
        end
        m1_req = 1;
        @(negedge clk);
        chk("lit_solo_then_gnt1", 32'(m1_gnt), 1);
        chk("lit_solo_then_gnt0", 32'(m0_gnt), 0);
        tick();
        clear();

        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(63) == 0);
            m0_req   = ($urandom_range(3) != 0);
            m1_req   = ($urandom_range(3) != 0);
            m0_we    = $urandom_range(1);
            m1_we    = $urandom_range(1);
            m0_be    = 4'($urandom);
            m1_be    = 4'($urandom);
            m0_addr  = 16'($urandom);
            m1_addr  = 16'($urandom);
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            mem_rdata = $urandom;
            tick();
        end
        rst = 0;
        clear();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
